// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver:
//   - rx_state_e : receiver FSM state encoding (IDLE..STOP)
//   - PRESCALE_* : supported oversampling ratios
//   - PAR_EVEN / PAR_ODD : parity type selector values
//   - LINE_IDLE  : idle level of the serial line
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE = 1'b1;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the UART receiver: brings the asynchronous serial line into the
// clock domain and produces a 3-sample majority vote around the bit centre.
//
// Ports:
//   clk       in   oversampling clock
//   rst_n     in   asynchronous active-low reset
//   rx_in     in   raw serial line (asynchronous)
//   edge_cnt  in   position inside the current bit (0..P-1)
//   prescale  in   latched, legalised oversampling ratio P
//   rx_s      out  synchronized serial line
//   bit_maj   out  majority of the samples taken at P/2-1, P/2, P/2+1;
//                  meaningful from edge_cnt = P/2+2 onwards
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  input  logic [CNT_W-1:0] edge_cnt,
  input  logic [CNT_W-1:0] prescale,
  output logic             rx_s,
  output logic             bit_maj
);

  logic [1:0]       sync_q, sync_d;
  logic [2:0]       samp_q, samp_d;
  logic [CNT_W-1:0] half;

  assign half = prescale >> 1;
  assign rx_s = sync_q[1];

  always_comb begin
    // NOTE: every always_comb output gets a default before any condition;
    // a path that leaves a variable unassigned would infer a latch.
    sync_d = {sync_q[0], rx_in};
    samp_d = samp_q;
    if (edge_cnt == half - CNT_W'(1)) samp_d[0] = rx_s;
    if (edge_cnt == half)             samp_d[1] = rx_s;
    if (edge_cnt == half + CNT_W'(1)) samp_d[2] = rx_s;
  end

  // Synchronizer resets to the idle level so leaving reset never looks like a
  // start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      sync_q <= {2{LINE_IDLE}};
      samp_q <= {3{LINE_IDLE}};
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
    end
  end

  assign bit_maj = (samp_q[0] & samp_q[1]) |
                   (samp_q[0] & samp_q[2]) |
                   (samp_q[1] & samp_q[2]);

endmodule : uart_rx_sampler

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit, oversampled PRESCALE times per bit.
//
// Ports:
//   CLK         in   oversampling clock (PRESCALE x baud)
//   RST         in   asynchronous active-low reset
//   RX_IN       in   serial line, idle high, asynchronous to CLK
//   PRESCALE    in   oversampling ratio (8/16/32; anything else acts as 8)
//   PAR_EN      in   1 = frame carries a parity bit
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   P_DATA      out  last good received byte
//   DATA_VALID  out  1-cycle strobe, P_DATA updated with a good frame
//   PAR_ERR     out  1-cycle strobe, parity mismatch in the frame just ended
//   STP_ERR     out  1-cycle strobe, stop bit sampled as 0
//
// PRESCALE/PAR_EN/PAR_TYP are captured on the start-detect cycle and held for
// the whole frame.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int CNT_W  = PRESCALE_WIDTH;
  localparam int BCNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  prescale_q, prescale_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_mis_q, par_mis_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic              data_valid_q, data_valid_d;
  logic              par_err_q, par_err_d;
  logic              stp_err_q, stp_err_d;

  logic              rx_s;
  logic              bit_maj;
  logic [CNT_W-1:0]  prescale_legal;
  logic [CNT_W-1:0]  half;
  logic              samp_valid;
  logic              bit_end;
  logic              par_expected;
  logic              stop_ok;
  logic              par_ok;

  uart_rx_sampler #(
    .CNT_W (CNT_W)
  ) u_sampler (
    .clk      (CLK),
    .rst_n    (RST),
    .rx_in    (RX_IN),
    .edge_cnt (edge_cnt_q),
    .prescale (prescale_q),
    .rx_s     (rx_s),
    .bit_maj  (bit_maj)
  );

  // Unsupported ratios fall back to 8.
  always_comb begin
    prescale_legal = CNT_W'(PRESCALE_8);
    if (PRESCALE == CNT_W'(PRESCALE_16)) prescale_legal = CNT_W'(PRESCALE_16);
    if (PRESCALE == CNT_W'(PRESCALE_32)) prescale_legal = CNT_W'(PRESCALE_32);
  end

  assign half       = prescale_q >> 1;
  assign samp_valid = (edge_cnt_q == half + CNT_W'(2));
  assign bit_end    = (edge_cnt_q == prescale_q - CNT_W'(1));

  assign par_expected = (par_typ_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);
  assign stop_ok      = bit_maj;
  assign par_ok       = ~(par_en_q & par_mis_q);

  // After reset the synchronizer needs two cycles to show the real line; a
  // start is only accepted once the line has then been seen idle, so a frame
  // already in flight when reset releases is skipped.
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & rx_s);
  end

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_mis_d    = par_mis_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != ST_IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        edge_cnt_d = '0;
        if (armed_q && !rx_s) begin
          // This cycle is edge 0 of the start bit.
          state_d    = ST_START;
          edge_cnt_d = CNT_W'(1);
          bit_cnt_d  = '0;
          par_mis_d  = 1'b0;
          prescale_d = prescale_legal;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end

      ST_START: begin
        if (samp_valid && bit_maj) begin
          // Line recovered before mid-bit: treat as a glitch.
          state_d    = ST_IDLE;
          edge_cnt_d = '0;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (samp_valid) shift_d = {bit_maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (samp_valid) par_mis_d = (bit_maj != par_expected);
        if (bit_end)    state_d   = ST_STOP;
      end

      ST_STOP: begin
        // Leave at mid-stop-bit so a following start edge is never missed.
        if (samp_valid) begin
          state_d    = ST_IDLE;
          edge_cnt_d = '0;
          stp_err_d  = ~stop_ok;
          par_err_d  = ~par_ok;
          if (stop_ok && par_ok) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      prescale_q   <= CNT_W'(PRESCALE_8);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      par_mis_q    <= 1'b0;
      settle_q     <= 2'd0;
      armed_q      <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_mis_q    <= par_mis_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed frames drive the serial line; each frame pushes its expected
// end-of-frame strobe into a queue, and an independent monitor pops and
// compares whenever the receiver raises any strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PRESCALE   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int dur);
    rx_in = b;
    tick(dur);
  endtask

  // With jitter, even-indexed bits are one cycle long and odd ones one short,
  // so every edge moves by up to one cycle while the frame length is kept.
  function automatic int bit_len(input int p, input int k, input bit jitter);
    if (!jitter) return p;
    return (k % 2 == 0) ? p + 1 : p - 1;
  endfunction

  task automatic send_frame(input logic [7:0] data, input bit with_par, input bit par_bit,
                            input bit stop_bit, input int p, input bit jitter);
    send_bit(1'b0, bit_len(p, 0, jitter));
    for (int i = 0; i < 8; i++) send_bit(data[i], bit_len(p, i + 1, jitter));
    if (with_par) send_bit(par_bit, bit_len(p, 9, jitter));
    send_bit(stop_bit, bit_len(p, with_par ? 10 : 9, jitter));
    rx_in = 1'b1;
  endtask

  task automatic expect_good(input logic [7:0] data);
    exp_t e;
    e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0; e.data = data;
    exp_q.push_back(e);
    last_good = data;
  endtask

  task automatic expect_err(input logic pe, input logic se);
    exp_t e;
    e.dv = 1'b0; e.pe = pe; e.se = se; e.data = last_good;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_p_data", p_data, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_par_err", par_err, 0);
    check("rst_stp_err", stp_err, 0);
  endtask

  // Monitor: any strobe consumes exactly one expectation; a strobe held for a
  // second cycle or an extra frame therefore shows up as unexpected.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (data_valid || par_err || stp_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {29'd0, data_valid, par_err, stp_err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_valid", data_valid, e.dv);
          check("par_err", par_err, e.pe);
          check("stp_err", stp_err, e.se);
          check("p_data", p_data, e.data);
        end
      end
    end
  end

  initial begin
    rx_in     = 1'b1;
    prescale  = 6'd8;
    par_en    = 1'b0;
    par_typ   = 1'b0;
    last_good = 8'h00;
    rst_n     = 1'b0;
    tick(3);
    check_reset_outputs();
    rst_n = 1'b1;
    tick(20);

    // 1: P=8, even parity, 0xA5 (four ones -> parity bit 0)
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, 1'b0);
    tick(24);
    drain("t1_drain");

    // 2: P=16, odd parity, 0x3C with parity bit 0 (should be 1)
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
    expect_err(1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, 1'b0);
    tick(48);
    drain("t2_drain");

    // 3: P=32, no parity, 0x81 with bad stop bit, then a good 0x81
    prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
    expect_err(1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 32, 1'b0);
    tick(96);
    expect_good(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 32, 1'b0);
    tick(96);
    drain("t3_drain");

    // Unsupported ratio 12 must behave as 8
    prescale = 6'd12;
    expect_good(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    tick(24);
    drain("illegal_prescale_drain");

    // 4: 2-cycle low glitch on the idle line, then 0x55
    prescale = 6'd8;
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(40);
    expect_good(8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8, 1'b0);
    tick(24);
    drain("t4_drain");

    // 5: back-to-back 0x12, 0x34 at P=16 with edge jitter
    prescale = 6'd16;
    expect_good(8'h12);
    expect_good(8'h34);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 16, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 16, 1'b1);
    tick(48);
    drain("t5_drain");

    // 6a: reset during data bit 4 (low) of 0xE5; reset releases while the
    // line is still low, so the remainder of the frame must be ignored.
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(((8'hE5 >> i) & 8'h01) != 0, 16);
    send_bit(1'b0, 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(2);
    rst_n = 1'b1;
    last_good = 8'h00;
    tick(12);
    for (int i = 5; i < 8; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    tick(12 * 16);
    check("post_reset_p_data", p_data, 0);
    drain("t6_abort_drain");

    // 6b: PAR_EN=1 latched at start, dropped mid-frame; 0x5A even parity = 0
    par_en = 1'b1; par_typ = 1'b0;
    expect_good(8'h5A);
    send_bit(1'b0, 16);
    par_en = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    tick(48);
    // Next frame picks up PAR_EN=0
    expect_good(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    tick(48);
    drain("t6_latch_drain");

    check("final_p_data", p_data, 8'h0F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
